// File: rtl/i2c_target_rx.sv
// i2c_target_rx: write-only I2C target receiver fed by a START/STOP/SCL-edge detector.
// Optional feature macro: I2C_GENERAL_CALL_EN also ACKs the general-call address 7'h00 (write).
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       scl_rise_in,
  input  logic       scl_fall_in,
  output logic       sda_oe_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       addr_match_out,
  output logic       busy_out
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_e;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       sda_oe_q;
  logic       rx_valid_q;
  logic       addr_match_q;
  logic       busy_q;
  logic [7:0] rx_data_q;

  // Byte as it stands once the current rising-edge bit is included.
  logic [7:0] rx_byte;
  logic       last_bit;
  logic       addr_ok;

  assign rx_byte  = {shift_q, sda_in};
  assign last_bit = (bit_cnt_q == 3'd7);

`ifdef I2C_GENERAL_CALL_EN
  assign addr_ok = !rx_byte[0] && ((rx_byte[7:1] == TARGET_ADDR) || (rx_byte[7:1] == 7'h00));
`else
  assign addr_ok = !rx_byte[0] && (rx_byte[7:1] == TARGET_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= 8'd0;
    end else begin
      rx_valid_q <= 1'b0;
      if (stop_in) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        sda_oe_q     <= 1'b0;
        addr_match_q <= 1'b0;
      end else if (start_in) begin
        state_q      <= ADDR;
        busy_q       <= 1'b1;
        bit_cnt_q    <= 3'd0;
        sda_oe_q     <= 1'b0;
        addr_match_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, DATA: begin
            if (scl_rise_in) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                if (state_q == DATA) begin
                  rx_data_q  <= rx_byte;
                  rx_valid_q <= 1'b1;
                  state_q    <= DATA_ACK;
                end else if (addr_ok) begin
                  state_q      <= ADDR_ACK;
                  addr_match_q <= 1'b1;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          // First fall drives the ACK, the following fall ends the ninth clock.
          ADDR_ACK, DATA_ACK: begin
            if (!scl_rise_in && scl_fall_in) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                state_q   <= DATA;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe_out     = sda_oe_q;
  assign rx_data_out    = rx_data_q;
  assign rx_valid_out   = rx_valid_q;
  assign addr_match_out = addr_match_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: scoreboard bench for i2c_target_rx driving START/STOP/SCL-edge pulses.
// Honours I2C_GENERAL_CALL_EN in its reference model when the macro is defined.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sda_in = 1'b1;
  logic       start_in = 1'b0;
  logic       stop_in = 1'b0;
  logic       scl_rise_in = 1'b0;
  logic       scl_fall_in = 1'b0;
  logic       sda_oe_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       addr_match_out;
  logic       busy_out;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  int         checksTotal = 0;
  int         checksPassed = 0;
  int         cycCnt = 0;
  int         strayOe = 0;
  bit         oeAllowed = 1'b0;
  bit         prevValid = 1'b0;
  logic [7:0] lastByte = 8'd0;
  logic [7:0] txData[0:3];

`ifdef I2C_GENERAL_CALL_EN
  bit gcEn = 1'b1;
`else
  bit gcEn = 1'b0;
`endif

  i2c_target_rx #(.TARGET_ADDR(7'h42)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sda_in        (sda_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .scl_rise_in   (scl_rise_in),
    .scl_fall_in   (scl_fall_in),
    .sda_oe_out    (sda_oe_out),
    .rx_data_out   (rx_data_out),
    .rx_valid_out  (rx_valid_out),
    .addr_match_out(addr_match_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference: a write to our own address (or general call when enabled) is acknowledged.
  function automatic bit refAddrAck(input logic [7:0] a);
    int addr7;
    int isRead;
    addr7  = int'(a) / 2;
    isRead = int'(a) % 2;
    return (isRead == 0) && ((addr7 == 'h42) || (gcEn && addr7 == 0));
  endfunction

  // Monitor: pops the scoreboard on each strobe, checks data, timing and strobe width.
  always @(negedge clk) begin
    if (rx_valid_out) begin
      checkOutput("rx_valid_width", prevValid, 0);
      if (expQ.size() == 0) begin
        checkOutput("rx_valid_unexpected", expQ.size(), 1);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rx_data", rx_data_out, monE.data);
        checkOutput("rx_valid_cycle", cycCnt, monE.cycle);
      end
    end
    if (sda_oe_out && !oeAllowed) strayOe++;
    prevValid = rx_valid_out;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b, input bit pushExp, input logic [7:0] data);
    sda_in = b;
    idle(1);
    if (pushExp) begin
      monE.data  = data;
      monE.cycle = cycCnt + 1;
      expQ.push_back(monE);
    end
    scl_rise_in = 1'b1;
    idle(1);
    scl_rise_in = 1'b0;
    idle(2);
    scl_fall_in = 1'b1;
    idle(1);
    scl_fall_in = 1'b0;
    idle(1);
  endtask

  task automatic sendByte(input logic [7:0] data, input int nBits, input bit expAck, input bit pushExp);
    for (int i = 7; i >= 8 - nBits; i--) begin
      if (i == 0) oeAllowed = expAck;
      sendBit(data[i], pushExp && (i == 0), data);
    end
    if (pushExp && nBits == 8) lastByte = data;
  endtask

  task automatic ackPhase(input bit expAck, input string name);
    checkOutput({name, "_oe_low"}, sda_oe_out, expAck);
    sda_in = 1'b1;
    idle(1);
    scl_rise_in = 1'b1;
    idle(1);
    scl_rise_in = 1'b0;
    idle(1);
    checkOutput({name, "_oe_high"}, sda_oe_out, expAck);
    scl_fall_in = 1'b1;
    idle(1);
    scl_fall_in = 1'b0;
    checkOutput({name, "_oe_release"}, sda_oe_out, 0);
    oeAllowed = 1'b0;
    idle(1);
  endtask

  task automatic doStart();
    start_in = 1'b1;
    idle(1);
    start_in = 1'b0;
    checkOutput("start_busy", busy_out, 1);
    checkOutput("start_addr_match", addr_match_out, 0);
    checkOutput("start_oe", sda_oe_out, 0);
  endtask

  task automatic doStop();
    stop_in = 1'b1;
    idle(1);
    stop_in = 1'b0;
    checkOutput("stop_busy", busy_out, 0);
    checkOutput("stop_addr_match", addr_match_out, 0);
    checkOutput("stop_rx_data_hold", rx_data_out, lastByte);
    idle(2);
  endtask

  // One transaction: START, address, nBytes from txData, optional partial byte, optional STOP.
  task automatic applyStimulus(input logic [7:0] addrByte, input int nBytes, input int abortBits, input bit endStop);
    bit ack;
    ack = refAddrAck(addrByte);
    doStart();
    sendByte(addrByte, 8, ack, 1'b0);
    checkOutput("addr_match", addr_match_out, ack);
    ackPhase(ack, "addr_ack");
    for (int b = 0; b < nBytes; b++) begin
      sendByte(txData[b], 8, ack, ack);
      ackPhase(ack, "data_ack");
    end
    if (abortBits > 0) sendByte(8'($urandom_range(0, 255)), abortBits, 1'b0, 1'b0);
    if (endStop) doStop();
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idle(3);
    checkOutput("reset_oe", sda_oe_out, 0);
    checkOutput("reset_valid", rx_valid_out, 0);
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_addr_match", addr_match_out, 0);
    checkOutput("reset_rx_data", rx_data_out, 0);
    rst_n = 1'b1;
    idle(2);

    // Reset asserted while the address ACK is being driven.
    doStart();
    sendByte(8'h84, 8, refAddrAck(8'h84), 1'b0);
    checkOutput("midack_oe", sda_oe_out, refAddrAck(8'h84));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midack_rst_oe", sda_oe_out, 0);
    checkOutput("midack_rst_valid", rx_valid_out, 0);
    checkOutput("midack_rst_busy", busy_out, 0);
    @(negedge clk);
    oeAllowed = 1'b0;
    lastByte  = 8'd0;
    rst_n     = 1'b1;
    idle(2);

    txData[0] = 8'hA5;
    applyStimulus(8'h84, 1, 0, 1'b1);
    txData[0] = 8'h11;
    applyStimulus(8'h86, 1, 0, 1'b1);
    applyStimulus(8'h85, 0, 0, 1'b0);
    txData[0] = 8'h3C;
    applyStimulus(8'h84, 1, 0, 1'b1);
    applyStimulus(8'h84, 0, 4, 1'b1);
    txData[0] = 8'h5A;
    applyStimulus(8'h84, 1, 0, 1'b1);
    txData[0] = 8'h77;
    applyStimulus(8'h00, 1, 0, 1'b1);

    for (int t = 0; t < 24; t++) begin
      logic [7:0] a;
      int         sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0: a = 8'h84;
        1: a = 8'h85;
        2: a = 8'h00;
        3: a = 8'($urandom_range(0, 255));
        default: a = 8'h84;
      endcase
      for (int k = 0; k < 4; k++) txData[k] = 8'($urandom_range(0, 255));
      applyStimulus(a, $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                    ($urandom_range(0, 3) != 0));
    end
    doStop();

    idle(5);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    checkOutput("stray_sda_oe", strayOe, 0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
